// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser: tracks held game keys and queues 3-bit events with valid/ready.
// Optional: define PS2_TYPEMATIC_REPEAT_EN to re-queue repeat makes for LEFT/RIGHT/DOWN.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] ps2_data_i,
  input  logic       ps2_data_en_i,
  output logic [2:0] event_o,
  output logic       event_valid_o,
  input  logic       event_ready_i,
  output logic [6:0] held_keys_o,
  output logic       overflow_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [6:0]      held_q, held_d;
  logic            push_q, push_d;
  logic [2:0]      push_code_q, push_code_d;
  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;

  logic [3:0]      base_dec, ext_dec;
  logic            make_hit;
  logic [2:0]      make_code;
  logic            pop, full, wr_en;

  // {hit, code} lookups for plain and E0-prefixed make codes
  function automatic logic [3:0] map_base(input logic [7:0] b);
    case (b)
      8'h29:   return {1'b1, 3'd4};
      8'h5A:   return {1'b1, 3'd5};
      8'h4D:   return {1'b1, 3'd6};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] map_ext(input logic [7:0] b);
    case (b)
      8'h6B:   return {1'b1, 3'd0};
      8'h74:   return {1'b1, 3'd1};
      8'h72:   return {1'b1, 3'd2};
      8'h75:   return {1'b1, 3'd3};
      default: return 4'b0000;
    endcase
  endfunction

  assign base_dec = map_base(ps2_data_i);
  assign ext_dec  = map_ext(ps2_data_i);

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    held_d      = held_q;
    push_d      = 1'b0;
    push_code_d = '0;
    make_hit    = 1'b0;
    make_code   = '0;
    if (ps2_data_en_i) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (ps2_data_i == 8'hE0)      state_d = EXT;
          else if (ps2_data_i == 8'hF0) state_d = BRK;
          else {make_hit, make_code} = base_dec;
        end
        EXT: begin
          if (ps2_data_i == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            {make_hit, make_code} = ext_dec;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (base_dec[3]) held_d[base_dec[2:0]] = 1'b0;
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (ext_dec[3]) held_d[ext_dec[2:0]] = 1'b0;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (make_hit) begin
      if (!held_q[make_code]) begin
        held_d[make_code] = 1'b1;
        push_d            = 1'b1;
        push_code_d       = make_code;
      end
`ifdef PS2_TYPEMATIC_REPEAT_EN
      else if (make_code <= 3'd2) begin
        push_d      = 1'b1;
        push_code_d = make_code;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      held_q      <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      held_q      <= held_d;
      push_q      <= push_d;
      push_code_q <= push_code_d;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full queue still lands
  assign pop   = event_valid_o & event_ready_i;
  assign full  = (cnt_q == FULL_CNT);
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_code_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_q & full & ~pop) ovf_q <= 1'b1;
    end
  end

  assign event_o       = mem_q[rd_q];
  assign event_valid_o = (cnt_q != '0);
  assign held_keys_o   = held_q;
  assign overflow_o    = ovf_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits between the PS/2 byte receiver and the user-input clock-crossing stage, in the PS/2 (CLOCK_50) domain.
- Parses PS/2 scan-code set 2 byte streams, including the E0 extended prefix and the F0 break prefix.
- Tracks which game keys are held, suppresses typematic repeats, and queues 3-bit game events in a small FIFO.
- Presents the events with a valid/ready handshake to the downstream event-consuming stage.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 500000, clk_i cycles allowed after a prefix byte before the parser abandons the sequence (10 ms at 50 MHz).

Ports:
- clk_i  input  1  PS/2-domain clock (50 MHz).
- rst_n_i  input  1  reset; synchronous, active-low.
- ps2_data_i  input  8  received PS/2 byte.
- ps2_data_en_i  input  1  one-cycle strobe; ps2_data_i is valid.
- event_o  output  3  head-of-queue event code.
- event_valid_o  output  1  queue non-empty.
- event_ready_i  input  1  consumer accepts event_o this cycle.
- held_keys_o  output  7  held bitmap, bit index = event code.
- overflow_o  output  1  sticky; an event was dropped because the queue was full.

Behaviour:
- Event codes and their set-2 make codes:
  - 0 LEFT = E0 6B.
  - 1 RIGHT = E0 74.
  - 2 DOWN = E0 72.
  - 3 ROTATE = E0 75 (up arrow).
  - 4 DROP = 29 (space).
  - 5 NEW_GAME = 5A (enter).
  - 6 PAUSE = 4D ('P').
  - Code 7 is never produced.
- Reset (rst_n_i low at a clk_i edge) sets:
  - parser FSM to IDLE, timeout counter to 0;
  - queue empty, so event_valid_o = 0 and event_o = 0;
  - held_keys_o = 0, overflow_o = 0.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. It advances only on cycles with ps2_data_en_i = 1.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - 29/5A/4D -> make event, stay IDLE.
    - Any other byte (AA, FA, E1, unmapped) is ignored, stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 6B/74/72/75 -> make event, go IDLE.
    - Any other byte is discarded, go IDLE.
  - BRK: any byte -> go IDLE. If it is a mapped non-extended code, clear that held bit.
  - EXT_BRK: any byte -> go IDLE. If it is a mapped extended code, clear that held bit.
- Timeout:
  - The counter resets on every accepted byte and counts while the FSM is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE on the next edge.
  - No event is produced on timeout and no held bit changes.
- Make event handling:
  - If the held bit is clear: set it and push the code.
  - If the held bit is already set: this is a typematic repeat; see Optional Feature.
- Latency: a byte strobed at edge N that pushes into an empty queue gives event_valid_o = 1 with the code on event_o after edge N+1.
- Queue:
  - Synchronous FIFO, registered outputs, first-word-fall-through.
  - A pop occurs when event_valid_o & event_ready_i.
  - Push and pop in the same cycle on a non-empty queue both take effect and the count is unchanged.
  - Push while full with no pop in the same cycle: the event is dropped, overflow_o is set and stays set until reset, and the held bit update still occurs.
  - Push while full with a pop in the same cycle: the push is accepted.
  - event_o is held stable while event_valid_o & !event_ready_i.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-sequence (for example after E0) discards the partial sequence and any queued events.

Optional Feature:
- Macro: PS2_TYPEMATIC_REPEAT_EN.
- Defined: repeat makes for LEFT, RIGHT and DOWN are pushed again (auto-shift); repeats for all other keys are suppressed.
- Undefined: every repeat make is suppressed; one event per physical press.

Test Plan:
- Bytes E0,6B -> one event 0 one cycle after the 6B strobe; held_keys_o = 7'b0000001. Then E0,F0,6B -> held_keys_o = 0 and no event.
- Bytes 29,29,29 then F0,29 -> exactly one event 4 with either macro setting. Bytes E0,74 ×3 -> one event 1 without the macro, three events 1 with it.
- Bytes E0, then TIMEOUT_CYCLES idle cycles, then 74 -> FSM back in IDLE before the 74 arrives; 74 is ignored; no event; held_keys_o unchanged.
- event_ready_i = 0; press and release 5 distinct keys (FIFO_DEPTH = 4) -> queue holds codes in press order; 5th event dropped; overflow_o = 1. Then ready = 1 -> 4 pops in order and event_valid_o falls.
- Queue holds 4 entries with ready = 1 continuously and a new make arrives -> push and pop in the same cycle; no drop; overflow_o stays 0.
- Bytes AA, FA, E1, 12 and E0,F0,29 -> no events; held_keys_o unchanged. Assert rst_n_i low after a lone F0 -> the next byte 4D gives event 6.
